// File: rtl/dn_port_sequencer_pkg.sv
// dn_port_pkg: shared types and constants for the Dn register port sequencer.
//   state_t        sequencer FSM states
//   kind_t         what a latched request will do to the RAM
//   SIZE_*         core write-size encodings (one-hot, byte has priority)
//   GRANT_*        arbiter grant identifiers
//   req_kind()     classifies a request from its we/size fields
//   merge_partial() builds the write-back word for a byte/word write
package dn_port_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    typedef enum logic [1:0] {
        KIND_NOP,      // core write with no size bit set: ack only
        KIND_READ,
        KIND_PARTIAL,  // byte or word write, needs read-modify-write
        KIND_LONG      // full-word write, single RAM cycle
    } kind_t;

    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;
    localparam logic [2:0] SIZE_LONG = 3'b100;

    localparam logic GRANT_CORE = 1'b0;
    localparam logic GRANT_DBG  = 1'b1;

    // Size bits are checked byte > word > long, so a malformed multi-bit
    // size still resolves to exactly one access width.
    function automatic kind_t req_kind(input logic we, input logic [2:0] size);
        if (!we)                return KIND_READ;
        if (size[0] || size[1]) return KIND_PARTIAL;
        if (size[2])            return KIND_LONG;
        return KIND_NOP;
    endfunction

    function automatic logic [31:0] merge_partial(input logic [31:0] old,
                                                  input logic [31:0] wdata,
                                                  input logic [2:0]  size);
        if (size[0]) return {old[31:8],  wdata[7:0]};
        return {old[31:16], wdata[15:0]};
    endfunction

endpackage

// File: rtl/dn_port_sequencer_if.sv
// dn_port_sequencer_if: request/response and RAM-side signals of the sequencer.
//   core_*   core execution port (req/we/addr/size/wdata in, ack/rdata out)
//   dbg_*    debug port, always full-word (req/we/addr/wdata in, ack/rdata out)
//   ram_*    single-port synchronous-read RAM connection
//   busy     sequencer not idle
// modport slave  : the sequencer side
// modport master : requesters plus RAM side
interface dn_port_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [2:0]            core_size;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_ack;
    logic [DATA_WIDTH-1:0] core_rdata;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_data_out;

    logic                  busy;

    modport slave (
        input  core_req, core_we, core_addr, core_size, core_wdata,
        output core_ack, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output ram_address, ram_data_in, ram_we,
        input  ram_data_out,
        output busy
    );

    modport master (
        output core_req, core_we, core_addr, core_size, core_wdata,
        input  core_ack, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  ram_address, ram_data_in, ram_we,
        output ram_data_out,
        input  busy
    );

endinterface

// File: rtl/dn_port_sequencer_arb.sv
// rr_arbiter2: two-input round-robin grant.
//   clock, reset     clock / async active-high reset
//   req_core, req_dbg request levels
//   update           strobe: record done_grant as the last winner
//   done_grant       identity of the transaction being completed
//   grant_valid      at least one request present
//   grant            winner (GRANT_CORE / GRANT_DBG)
module rr_arbiter2
    import dn_port_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_core,
    input  logic req_dbg,
    input  logic update,
    input  logic done_grant,
    output logic grant_valid,
    output logic grant
);

    logic last_grant;

    // Starts at DBG so the core wins the first tie after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       last_grant <= GRANT_DBG;
        else if (update) last_grant <= done_grant;
    end

    always_comb begin
        grant_valid = req_core | req_dbg;
        if (req_core && req_dbg) grant = ~last_grant;
        else if (req_core)       grant = GRANT_CORE;
        else                     grant = GRANT_DBG;
    end

endmodule

// File: rtl/dn_port_sequencer.sv
// dn_port_sequencer: shares the single-port Dn RAM between core and debug
// ports and emulates byte/word writes by read-modify-write.
//   clock   sole clock, rising edge
//   reset   async active-high
//   bus     dn_port_sequencer_if.slave: core/dbg request ports, RAM port, busy
// Latency from grant to ack: long write 1, read 2, byte/word write 3,
// size-000 core write 1 (no RAM access).
module dn_port_sequencer
    import dn_port_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    dn_port_sequencer_if.slave  bus
);

    state_t                state, state_n;
    kind_t                 kind_q, sel_kind;
    logic                  gnt_q, arb_gnt, arb_valid, nxt_gnt, take, upd;
    logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
    logic [2:0]            size_q, sel_size;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] wdata_q, sel_wdata, old_q, din_q, merged;
    logic [DATA_WIDTH-1:0] core_rdata_q, dbg_rdata_q;
    logic                  core_ack_q, dbg_ack_q;
    logic                  ram_we_c;
    logic [ADDR_WIDTH-1:0] ram_addr_c;
    logic [DATA_WIDTH-1:0] ram_din_c;

    rr_arbiter2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_core    (bus.core_req),
        .req_dbg     (bus.dbg_req),
        .update      (upd),
        .done_grant  (gnt_q),
        .grant_valid (arb_valid),
        .grant       (arb_gnt)
    );

    // Requests are only taken in IDLE; gating with reset keeps a pending
    // long write from reaching the RAM combinationally while in reset.
    assign take      = (state == IDLE) && arb_valid && !reset;
    assign sel_we    = (arb_gnt == GRANT_DBG) ? bus.dbg_we    : bus.core_we;
    assign sel_addr  = (arb_gnt == GRANT_DBG) ? bus.dbg_addr  : bus.core_addr;
    assign sel_wdata = (arb_gnt == GRANT_DBG) ? bus.dbg_wdata : bus.core_wdata;
    assign sel_size  = (arb_gnt == GRANT_DBG) ? SIZE_LONG     : bus.core_size;
    assign sel_kind  = req_kind(sel_we, sel_size);
    assign nxt_gnt   = take ? arb_gnt : gnt_q;
    assign merged    = merge_partial(old_q, wdata_q, size_q);

    always_comb begin
        state_n    = state;
        ram_we_c   = 1'b0;
        ram_addr_c = addr_q;   // hold the latched address when not accessing
        ram_din_c  = din_q;
        upd        = 1'b0;
        case (state)
            IDLE: if (take) begin
                ram_addr_c = sel_addr;
                case (sel_kind)
                    KIND_LONG: begin
                        ram_we_c  = 1'b1;
                        ram_din_c = sel_wdata;
                        state_n   = DONE;
                    end
                    KIND_READ, KIND_PARTIAL: state_n = RD;
                    default:                 state_n = DONE;
                endcase
            end
            RD:   state_n = (kind_q == KIND_READ) ? DONE : WR;
            WR: begin
                ram_we_c  = 1'b1;
                ram_din_c = merged;
                state_n   = DONE;
            end
            DONE: begin
                upd     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gnt_q        <= GRANT_CORE;
            kind_q       <= KIND_NOP;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            din_q        <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
            core_ack_q   <= 1'b0;
            dbg_ack_q    <= 1'b0;
        end else begin
            state <= state_n;
            din_q <= ram_din_c;
            if (take) begin
                gnt_q   <= arb_gnt;
                kind_q  <= sel_kind;
                addr_q  <= sel_addr;
                size_q  <= sel_size;
                wdata_q <= sel_wdata;
            end
            if (state == RD) begin
                old_q <= bus.ram_data_out;
                if (kind_q == KIND_READ) begin
                    if (gnt_q == GRANT_DBG) dbg_rdata_q  <= bus.ram_data_out;
                    else                    core_rdata_q <= bus.ram_data_out;
                end
            end
            // Ack is registered so it is high exactly during the DONE cycle.
            core_ack_q <= (state_n == DONE) && (nxt_gnt == GRANT_CORE);
            dbg_ack_q  <= (state_n == DONE) && (nxt_gnt == GRANT_DBG);
        end
    end

    assign bus.ram_we      = ram_we_c;
    assign bus.ram_address = ram_addr_c;
    assign bus.ram_data_in = ram_din_c;
    assign bus.core_ack    = core_ack_q;
    assign bus.dbg_ack     = dbg_ack_q;
    assign bus.core_rdata  = core_rdata_q;
    assign bus.dbg_rdata   = dbg_rdata_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_dn_port_sequencer.sv
// Directed bench for dn_port_sequencer with a behavioural 8x32
// synchronous-read RAM attached to the ram_* port.
module tb_dn_port_sequencer;
    import dn_port_pkg::*;

    logic clock;
    logic reset;

    dn_port_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    dn_port_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [8] = '{default: 32'h0};
    always @(posedge clock) begin
        if (bus.ram_we === 1'b1) mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_address];
    end

    int we_cnt = 0, cack_cnt = 0, dack_cnt = 0;
    always @(posedge clock) begin
        if (bus.ram_we === 1'b1)   we_cnt++;
        if (bus.core_ack === 1'b1) cack_cnt++;
        if (bus.dbg_ack === 1'b1)  dack_cnt++;
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request from IDLE, waits (bounded) for its ack and
    // returns grant-to-ack latency; leaves the bench in the next IDLE cycle.
    task automatic run(input string tag, input logic is_dbg, input logic we,
                       input logic [2:0] size, input logic [2:0] addr,
                       input logic [31:0] wdata, output int lat);
        if (is_dbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end else begin
            bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr;
            bus.core_size = size; bus.core_wdata = wdata;
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if ((is_dbg ? bus.dbg_ack : bus.core_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.core_req = 1'b0;
        bus.dbg_req  = 1'b0;
        if (lat < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        int lat, w0, c0, d0, n, last_cyc;
        logic [3:0] ord;
        logic both, gap_ok, got;

        reset = 1'b1;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_size = 0; bus.core_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_core_ack",   32'(bus.core_ack), 32'd0);
        chk("rst_dbg_ack",    32'(bus.dbg_ack), 32'd0);
        chk("rst_busy",       32'(bus.busy), 32'd0);
        chk("rst_ram_we",     32'(bus.ram_we), 32'd0);
        chk("rst_core_rdata", bus.core_rdata, 32'h0);
        chk("rst_dbg_rdata",  bus.dbg_rdata, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        // long write then read of D3
        w0 = we_cnt;
        run("lw_d3", 1'b0, 1'b1, SIZE_LONG, 3'd3, 32'h12345678, lat);
        chk("lw_lat", lat, 1);
        chk("lw_we_cycles", we_cnt - w0, 1);
        chk("lw_mem", mem[3], 32'h12345678);
        w0 = we_cnt;
        run("rd_d3", 1'b0, 1'b0, 3'b000, 3'd3, 32'h0, lat);
        chk("rd_lat", lat, 2);
        chk("rd_no_we", we_cnt - w0, 0);
        chk("rd_data", bus.core_rdata, 32'h12345678);

        // byte write read-modify-write
        run("lw_d5a", 1'b0, 1'b1, SIZE_LONG, 3'd5, 32'hAABBCCDD, lat);
        w0 = we_cnt;
        run("bw_d5", 1'b0, 1'b1, SIZE_BYTE, 3'd5, 32'h000000EE, lat);
        chk("bw_lat", lat, 3);
        chk("bw_we_cycles", we_cnt - w0, 1);
        chk("bw_mem", mem[5], 32'hAABBCCEE);
        chk("bw_rdata_kept", bus.core_rdata, 32'h12345678);

        // word write, then size 000, then multi-bit size (byte wins)
        run("lw_d5b", 1'b0, 1'b1, SIZE_LONG, 3'd5, 32'hAABBCCDD, lat);
        run("ww_d5", 1'b0, 1'b1, SIZE_WORD, 3'd5, 32'h00001122, lat);
        chk("ww_lat", lat, 3);
        chk("ww_mem", mem[5], 32'hAABB1122);
        w0 = we_cnt;
        run("nop_d5", 1'b0, 1'b1, 3'b000, 3'd5, 32'hFFFFFFFF, lat);
        chk("nop_lat", lat, 1);
        chk("nop_no_we", we_cnt - w0, 0);
        chk("nop_mem", mem[5], 32'hAABB1122);
        run("prio_d5", 1'b0, 1'b1, 3'b111, 3'd5, 32'h00003344, lat);
        chk("prio_byte_mem", mem[5], 32'hAABB1144);

        // debug write leaves last_grant = DBG so the core wins the next tie
        run("dw_d6", 1'b1, 1'b1, 3'b000, 3'd6, 32'h00000066, lat);
        chk("dw_lat", lat, 1);
        chk("dw_mem", mem[6], 32'h00000066);

        // both ports continuously requesting
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 3'd0; bus.core_size = SIZE_LONG;
        bus.core_wdata = 32'h00000011;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 3'd1; bus.dbg_wdata = 32'h00000022;
        c0 = cack_cnt; d0 = dack_cnt;
        ord = 4'b0; n = 0; last_cyc = 0; both = 0; gap_ok = 1;
        for (int i = 1; i <= 40 && n < 4; i++) begin
            @(posedge clock); #1;
            if (bus.core_ack === 1'b1 && bus.dbg_ack === 1'b1) both = 1;
            if (bus.core_ack === 1'b1 || bus.dbg_ack === 1'b1) begin
                ord = {ord[2:0], bus.dbg_ack};
                if (n > 0 && i - last_cyc != 2) gap_ok = 0;
                last_cyc = i;
                n++;
            end
        end
        bus.core_req = 0; bus.dbg_req = 0;
        @(posedge clock); #1;
        chk("tie_count", n, 4);
        chk("tie_order", 32'(ord), 32'b0101);
        chk("tie_no_dual_ack", 32'(both), 32'd0);
        chk("tie_spacing", 32'(gap_ok), 32'd1);
        chk("tie_core_acks", cack_cnt - c0, 2);
        chk("tie_dbg_acks", dack_cnt - d0, 2);
        chk("tie_mem0", mem[0], 32'h00000011);
        chk("tie_mem1", mem[1], 32'h00000022);

        // reset in RD of a byte write
        run("lw_d2", 1'b0, 1'b1, SIZE_LONG, 3'd2, 32'h01020304, lat);
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 3'd2; bus.core_size = SIZE_BYTE;
        bus.core_wdata = 32'h000000FF;
        @(posedge clock); #1;
        chk("abort_busy_in_rd", 32'(bus.busy), 32'd1);
        c0 = cack_cnt;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_core_ack", 32'(bus.core_ack), 32'd0);
        chk("abort_ram_we", 32'(bus.ram_we), 32'd0);
        chk("abort_core_rdata", bus.core_rdata, 32'h0);
        chk("abort_dbg_rdata", bus.dbg_rdata, 32'h0);
        bus.core_req = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_no_ack", cack_cnt - c0, 0);
        chk("abort_mem", mem[2], 32'h01020304);

        // debug read while a core long write waits
        run("dw_d7", 1'b1, 1'b1, 3'b000, 3'd7, 32'hCAFEF00D, lat);
        run("rd_d3b", 1'b0, 1'b0, 3'b000, 3'd3, 32'h0, lat);
        chk("rd_d3b_data", bus.core_rdata, 32'h12345678);
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 3'd4; bus.core_size = SIZE_LONG;
        bus.core_wdata = 32'h00000044;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 3'd7; bus.dbg_wdata = 32'h0;
        c0 = cack_cnt;
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (bus.dbg_ack === 1'b1) begin got = 1; break; end
        end
        bus.dbg_req = 0;
        chk("dr_ack_seen", 32'(got), 32'd1);
        chk("dr_dbg_rdata", bus.dbg_rdata, 32'hCAFEF00D);
        chk("dr_core_rdata_kept", bus.core_rdata, 32'h12345678);
        chk("dr_core_not_yet", cack_cnt - c0, 0);
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (bus.core_ack === 1'b1) begin got = 1; break; end
        end
        bus.core_req = 0;
        chk("pend_core_ack", 32'(got), 32'd1);
        chk("pend_mem4", mem[4], 32'h00000044);
        chk("pend_core_rdata_kept", bus.core_rdata, 32'h12345678);
        @(posedge clock); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
